// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle between io_serdes and the digit-serial adder.
// Optional ovf signal exists only when DSA_SIGNED_OVF_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   z;
`ifdef DSA_SIGNED_OVF_EN
    logic             ovf;
`endif

    modport master (
        output a, b, start,
        input  busy, done, z
`ifdef DSA_SIGNED_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  a, b, start,
        output busy, done, z
`ifdef DSA_SIGNED_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder, DIGIT bits per clock, start/done handshake.
// Optional signed overflow flag: define DSA_SIGNED_OVF_EN.
module digit_serial_adder #(
    parameter int WIDTH = 24,
    parameter int DIGIT = 4
) (
    input logic clk,
    input logic rst,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   z_q;
    logic             busy_q;
    logic             done_q;
    logic [DIGIT:0]   dsum;
    logic             last;

    assign dsum = {1'b0, op_a_q[DIGIT-1:0]}
                + {1'b0, op_b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};

    // New digit enters at the top; the oldest low bits fall off.
    assign sum_nxt = WIDTH'({dsum[DIGIT-1:0], sum_q} >> DIGIT);

    assign last = (cnt_q == CW'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DSA_SIGNED_OVF_EN
    logic sa_q;
    logic sb_q;
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                sa_q <= bus.a[WIDTH-1];
                sb_q <= bus.b[WIDTH-1];
            end
            if (state_q == RUN && last) begin
                ovf_q <= (sa_q == sb_q)
                      && (sum_nxt[WIDTH-1] != sa_q);
            end
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_a_q  <= bus.a;
                        op_b_q  <= bus.b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    carry_q <= dsum[DIGIT];
                    sum_q   <= sum_nxt;
                    op_a_q  <= op_a_q >> DIGIT;
                    op_b_q  <= op_b_q >> DIGIT;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        z_q    <= {dsum[DIGIT], sum_nxt};
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;
endmodule
